wb_dual_arbiter: RTL and testbench

Two-master to one-slave Wishbone B4 arbiter that sits directly downstream of the `cpu` top. It consumes the packed dual-master bus (lane 0 = instruction cache, lane 1 = data cache) and drives a single 32-bit slave port toward memory and peripherals. The arbiter grants one master at a time with round-robin fairness and holds the grant for the whole `cyc` window, so cache-line bursts are never interleaved. It routes slave responses back only to the owning master.

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_dual_arbiter_if.sv | 28 ++
 rtl/wb_arb_watchdog.sv | 17 +
 rtl/wb_dual_arbiter.sv | 64 ++++++
 tb/tb_wb_dual_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding, CTI codes and lane widths for the dual-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int CTI_W = 3;
  localparam int BTE_W = 2;
endpackage

// File: rtl/wb_dual_arbiter_if.sv
// wb_dual_arbiter_if: packed dual-master bus plus single slave port; slave = arbiter view, master = environment view
interface wb_dual_arbiter_if;
  import wb_arb_pkg::*;
  logic [1:0] m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, m_rty_o;
  logic [2*ADR_W-1:0] m_adr_i;
  logic [2*SEL_W-1:0] m_sel_i;
  logic [2*DAT_W-1:0] m_dat_i, m_dat_o;
  logic [2*CTI_W-1:0] m_cti_i;
  logic [2*BTE_W-1:0] m_bte_i;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
  logic [ADR_W-1:0] s_adr_o;
  logic [SEL_W-1:0] s_sel_o;
  logic [DAT_W-1:0] s_dat_o, s_dat_i;
  logic [CTI_W-1:0] s_cti_o;
  logic [BTE_W-1:0] s_bte_o;
  modport slave (
    input m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
    input s_ack_i, s_err_i, s_rty_i, s_dat_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i,
    input m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o
  );
endinterface

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts stalled strobe cycles and flags an abort on the TIMEOUT_CYCLES-th one
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  input logic stall,
  input logic clear,
  output logic timeout
);
  logic [7:0] count;
  assign timeout = stall && count == 8'(TIMEOUT_CYCLES - 1);
  // restart on any response or ownership change, otherwise count stalled cycles
  always_ff @(posedge clk)
    if (!rst || clear) count <= '0;
    else if (stall) count <= count + 8'd1;
endmodule

// File: rtl/wb_dual_arbiter.sv
// wb_dual_arbiter: two-master round-robin Wishbone arbiter, grant locked for the whole cyc window; watchdog abort under WB_ARB_TIMEOUT_EN
module wb_dual_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  wb_dual_arbiter_if.slave bus,
  output logic [1:0] grant_o,
  output logic bus_timeout_o
);
  import wb_arb_pkg::*;
  state_t state, state_next;
  logic last, k, own, timeout;
  logic [1:0] req;
  assign own = state != IDLE;
  assign k = state == OWN1;
  assign grant_o = {state == OWN1, state == OWN0};
  assign bus_timeout_o = timeout;
`ifdef WB_ARB_TIMEOUT_EN
  logic [1:0] blocked;
  // an aborted master stays locked out until it drops cyc
  always_ff @(posedge clk)
    if (!rst) blocked <= '0;
    else blocked <= (blocked & bus.m_cyc_i) | (timeout ? grant_o : 2'b00);
  assign req = bus.m_cyc_i & ~blocked;
  wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk,
    .rst,
    .stall(bus.s_stb_o & ~(bus.s_ack_i | bus.s_err_i | bus.s_rty_i)),
    .clear(state_next != state || bus.s_ack_i || bus.s_err_i || bus.s_rty_i),
    .timeout
  );
`else
  assign req = bus.m_cyc_i;
  assign timeout = 1'b0;
`endif
  // state and round-robin history; last starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state && state_next != IDLE) last <= state_next == OWN1;
    end
  // round-robin from idle, hold while the owner keeps cyc, hand off directly otherwise
  always_comb begin
    state_next = state;
    if (!own) state_next = req == 2'b11 ? (last ? OWN0 : OWN1) : req[0] ? OWN0 : req[1] ? OWN1 : IDLE;
    else state_next = timeout ? IDLE : bus.m_cyc_i[k] ? state : req[~k] ? (k ? OWN0 : OWN1) : IDLE;
  end
  assign bus.s_cyc_o = own & bus.m_cyc_i[k];
  assign bus.s_stb_o = own & bus.m_stb_i[k];
  assign bus.s_we_o = own & bus.m_we_i[k];
  assign bus.s_adr_o = own ? bus.m_adr_i[k*ADR_W +: ADR_W] : '0;
  assign bus.s_sel_o = own ? bus.m_sel_i[k*SEL_W +: SEL_W] : '0;
  assign bus.s_dat_o = own ? bus.m_dat_i[k*DAT_W +: DAT_W] : '0;
  assign bus.s_cti_o = own ? bus.m_cti_i[k*CTI_W +: CTI_W] : '0;
  assign bus.s_bte_o = own ? bus.m_bte_i[k*BTE_W +: BTE_W] : '0;
  assign bus.m_ack_o = grant_o & {2{bus.s_ack_i}};
  assign bus.m_err_o = grant_o & {2{bus.s_err_i | timeout}};
  assign bus.m_rty_o = grant_o & {2{bus.s_rty_i}};
  assign bus.m_dat_o = {{DAT_W{grant_o[1]}} & bus.s_dat_i, {DAT_W{grant_o[0]}} & bus.s_dat_i};
endmodule

// File: tb/tb_wb_dual_arbiter.sv
// tb_wb_dual_arbiter: directed plan scenarios plus randomized traffic against an ownership-level reference model
module tb_wb_dual_arbiter;
  import wb_arb_pkg::*;
  localparam int TO = 16;
  logic clk = 0;
  logic rst = 0;
  logic [1:0] grant;
  logic bus_timeout;
  int checks = 0, errors = 0;
  int owner = -1, last = 1, stall = 0;
  bit blk [2];
  wb_dual_arbiter_if bus();
  wb_dual_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_o(grant), .bus_timeout_o(bus_timeout)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_resp();
    return bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
  endfunction

  function automatic bit exp_timeout();
`ifdef WB_ARB_TIMEOUT_EN
    return owner >= 0 && bus.m_stb_i[owner] && !any_resp() && stall + 1 == TO;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    int o = owner < 0 ? 0 : owner;
    bit on = owner >= 0;
    logic [1:0] g = on ? 2'(1 << o) : 2'b00;
    bit to = exp_timeout();
    check("grant", grant, g);
    check("s_ctl", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o},
          on ? {bus.m_cyc_i[o], bus.m_stb_i[o], bus.m_we_i[o]} : 3'b000);
    check("s_req", {bus.s_adr_o, bus.s_sel_o, bus.s_dat_o, bus.s_cti_o, bus.s_bte_o},
          on ? {bus.m_adr_i[o*32 +: 32], bus.m_sel_i[o*4 +: 4], bus.m_dat_i[o*32 +: 32],
                bus.m_cti_i[o*3 +: 3], bus.m_bte_i[o*2 +: 2]} : 73'b0);
    check("m_ack", bus.m_ack_o, on && bus.s_ack_i ? g : 2'b00);
    check("m_err", bus.m_err_o, on && (bus.s_err_i || to) ? g : 2'b00);
    check("m_rty", bus.m_rty_o, on && bus.s_rty_i ? g : 2'b00);
    check("m_dat", bus.m_dat_o, on ? 64'(bus.s_dat_i) << (32 * o) : 64'b0);
    check("timeout", bus_timeout, to);
  endtask

  task automatic update_model();
    int nxt;
    bit to, r0, r1;
    if (!rst) begin
      owner = -1;
      last = 1;
      stall = 0;
      blk[0] = 0;
      blk[1] = 0;
      return;
    end
    to = exp_timeout();
    r0 = bus.m_cyc_i[0] && !blk[0];
    r1 = bus.m_cyc_i[1] && !blk[1];
    if (owner < 0) nxt = (r0 && r1) ? 1 - last : r0 ? 0 : r1 ? 1 : -1;
    else if (to) nxt = -1;
    else if (bus.m_cyc_i[owner]) nxt = owner;
    else nxt = (owner == 0 ? r1 : r0) ? 1 - owner : -1;
    for (int i = 0; i < 2; i++) blk[i] = blk[i] && bus.m_cyc_i[i];
    if (to) blk[owner] = 1;
    if (nxt != owner || any_resp()) stall = 0;
    else if (owner >= 0 && bus.m_stb_i[owner]) stall++;
    if (nxt >= 0 && nxt != owner) last = nxt;
    owner = nxt;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [2:0] cti);
    bus.m_cyc_i[i] = cyc;
    bus.m_stb_i[i] = stb;
    bus.m_we_i[i] = we;
    bus.m_adr_i[i*32 +: 32] = adr;
    bus.m_sel_i[i*4 +: 4] = 4'($urandom);
    bus.m_dat_i[i*32 +: 32] = $urandom;
    bus.m_cti_i[i*3 +: 3] = cti;
    bus.m_bte_i[i*2 +: 2] = 2'($urandom);
  endtask

  task automatic set_s(input bit ack, input bit err, input bit rty, input logic [31:0] dat);
    bus.s_ack_i = ack;
    bus.s_err_i = err;
    bus.s_rty_i = rty;
    bus.s_dat_i = dat;
  endtask

  task automatic idle_inputs();
    set_m(0, 0, 0, 0, 0, CTI_CLASSIC);
    set_m(1, 0, 0, 0, 0, CTI_CLASSIC);
    set_s(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    cycle();
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", bus.s_cyc_o, 1'b0);
    check("rst_timeout", bus_timeout, 1'b0);
    rst = 1;
    // single request from master 0
    set_m(0, 1, 1, 0, 32'h1000, CTI_CLASSIC);
    #1 check("t1_wait", bus.s_cyc_o, 1'b0);
    cycle();
    set_s(1, 0, 0, 32'hDEADBEEF);
    #1;
    check("t1_s_cyc", bus.s_cyc_o, 1'b1);
    check("t1_adr", bus.s_adr_o, 32'h1000);
    check("t1_ack", bus.m_ack_o, 2'b01);
    check("t1_dat_lo", bus.m_dat_o[31:0], 32'hDEADBEEF);
    check("t1_dat_hi", bus.m_dat_o[63:32], 32'h0);
    cycle();
    idle_inputs();
    cycle();
    // simultaneous requests, then direct handoff
    do_reset();
    set_m(0, 1, 1, 0, 32'h2000, CTI_CLASSIC);
    set_m(1, 1, 1, 1, 32'h3000, CTI_CLASSIC);
    cycle();
    #1 check("t2_grant0", grant, 2'b01);
    cycle();
    set_m(0, 0, 0, 0, 32'h2000, CTI_CLASSIC);
    #1 check("t2_hold", grant, 2'b01);
    cycle();
    #1;
    check("t2_handoff", grant, 2'b10);
    check("t2_s_cyc", bus.s_cyc_o, 1'b1);
    cycle();
    idle_inputs();
    cycle();
    // burst lock with a mid-burst competing request
    do_reset();
    set_m(1, 1, 1, 0, 32'h4000, CTI_INCR);
    cycle();
    for (int b = 0; b < 8; b++) begin
      set_m(1, 1, 1, 0, 32'h4000 + 32'(4 * b), b == 7 ? CTI_EOB : CTI_INCR);
      if (b >= 2) set_m(0, 1, 1, 0, 32'h5000, CTI_CLASSIC);
      set_s(1, 0, 0, $urandom);
      #1;
      check("t3_ack", bus.m_ack_o, 2'b10);
      check("t3_cti", bus.s_cti_o, b == 7 ? CTI_EOB : CTI_INCR);
      cycle();
    end
    set_m(1, 0, 0, 0, 32'h0, CTI_CLASSIC);
    set_s(0, 0, 0, 0);
    #1 check("t3_locked", grant, 2'b10);
    cycle();
    #1 check("t3_m0_granted", grant, 2'b01);
    cycle();
    idle_inputs();
    cycle();
    // error and retry forwarding
    do_reset();
    set_m(1, 1, 1, 1, 32'h6000, CTI_CLASSIC);
    cycle();
    set_s(0, 1, 0, 0);
    #1;
    check("t4_err", bus.m_err_o, 2'b10);
    check("t4_ack", bus.m_ack_o, 2'b00);
    cycle();
    set_s(0, 0, 1, 0);
    #1 check("t4_rty", bus.m_rty_o, 2'b10);
    cycle();
    idle_inputs();
    cycle();
    // stalled slave
    do_reset();
    set_m(0, 1, 1, 0, 32'h7000, CTI_CLASSIC);
    cycle();
    for (int i = 1; i <= 20; i++) begin
      #1;
`ifdef WB_ARB_TIMEOUT_EN
      check("t5_timeout", bus_timeout, i == TO);
      check("t5_s_cyc", bus.s_cyc_o, i <= TO);
      if (i == TO) check("t5_err", bus.m_err_o, 2'b01);
`else
      check("t5_timeout", bus_timeout, 1'b0);
      check("t5_s_cyc", bus.s_cyc_o, 1'b1);
`endif
      cycle();
    end
    idle_inputs();
    cycle();
    // reset during beat 3 of a burst
    do_reset();
    set_m(0, 1, 1, 0, 32'h8000, CTI_INCR);
    cycle();
    for (int b = 1; b <= 3; b++) begin
      set_s(1, 0, 0, $urandom);
      if (b == 3) rst = 0;
      cycle();
    end
    rst = 1;
    #1;
    check("t6_grant", grant, 2'b00);
    check("t6_s_cyc", bus.s_cyc_o, 1'b0);
    check("t6_s_adr", bus.s_adr_o, 32'h0);
    check("t6_ack", bus.m_ack_o, 2'b00);
    cycle();
    idle_inputs();
    cycle();
    // randomized traffic with quiet-slave stretches
    for (int n = 0; n < 3000; n++) begin
      bit quiet = (n / 100) % 5 == 4;
      for (int i = 0; i < 2; i++) begin
        bit c = bus.m_cyc_i[i] ^ ($urandom_range(0, 7) == 0);
        logic [2:0] cti = $urandom_range(0, 2) == 0 ? CTI_CLASSIC : $urandom_range(0, 1) ? CTI_INCR : CTI_EOB;
        set_m(i, c, c && $urandom_range(0, 3) != 0, 1'($urandom), $urandom, cti);
      end
      set_s(!quiet && $urandom_range(0, 2) == 0, !quiet && $urandom_range(0, 19) == 0,
            !quiet && $urandom_range(0, 19) == 0, $urandom);
      rst = $urandom_range(0, 299) != 0;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
